// File: rtl/double_ask_pkg.sv
// Shared defaults and helpers for the 2ASK loopback modem.
package double_ask_pkg;

    localparam int DATA_W      = 16;
    localparam int SYM_CYCLES  = 50;
    localparam int CARRIER_DIV = 10;
    localparam int THRESH      = SYM_CYCLES / 4;

    // Width large enough to hold a full-symbol count without wrapping.
    function automatic int acc_width(input int sym_cycles);
        return $clog2(sym_cycles + 1);
    endfunction

endpackage

// File: rtl/double_ask_top_ask_demod.sv
// Integrate-and-dump demodulator: counts high samples per symbol window and thresholds.
module ask_demod
    import double_ask_pkg::*;
#(
    parameter int SYM_CYCLES = double_ask_pkg::SYM_CYCLES,
    parameter int THRESH     = double_ask_pkg::THRESH
) (
    input  logic clk,
    input  logic rst,
    input  logic ask_mod,
    input  logic window_end,
    output logic data_out,
    output logic data_valid
);

    localparam int ACC_W = acc_width(SYM_CYCLES);

    logic [ACC_W-1:0] acc_p1;
    logic [ACC_W-1:0] sum_p0;

    // The final sample of the window takes part in the decision.
    assign sum_p0 = acc_p1 + ACC_W'(ask_mod);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p1     <= '0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
        end else if (window_end) begin
            acc_p1     <= '0;
            data_out   <= (sum_p0 >= ACC_W'(THRESH));
            data_valid <= 1'b1;
        end else begin
            acc_p1     <= sum_p0;
            data_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/double_ask_top.sv
// 2ASK loopback top: timing, frame serialiser, OOK modulator, internal demodulator.
// Define DOUBLE_ASK_MOD_OUT_EN to expose the registered modulated signal on ask_mod_o.
module double_ask_top
    import double_ask_pkg::*;
#(
    parameter int DATA_W      = double_ask_pkg::DATA_W,
    parameter int SYM_CYCLES  = double_ask_pkg::SYM_CYCLES,
    parameter int CARRIER_DIV = double_ask_pkg::CARRIER_DIV,
    parameter int THRESH      = double_ask_pkg::THRESH
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_out,
    output logic              data_valid
`ifdef DOUBLE_ASK_MOD_OUT_EN
    ,
    output logic              ask_mod_o
`endif
);

    localparam int SYM_W = $clog2(SYM_CYCLES);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int CAR_W = $clog2(CARRIER_DIV);

    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CARRIER_DIV - 1);
    localparam logic [CAR_W-1:0] CAR_HALF = CAR_W'(CARRIER_DIV / 2);

    logic [SYM_W-1:0]  sym_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CAR_W-1:0]  car_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic              sym_end;
    logic              frame_start;
    logic              carrier;
    logic              tx_bit;
    logic              ask_mod_p1;
    logic              window_end_p1;

    assign sym_end     = (sym_cnt == SYM_LAST);
    assign frame_start = (sym_cnt == '0) && (bit_cnt == '0);
    assign carrier     = (car_cnt < CAR_HALF);
    // On the load cycle the new word's MSB is used directly so the first symbol is full length.
    assign tx_bit      = frame_start ? data_in[DATA_W-1] : tx_shift[DATA_W-1];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sym_cnt  <= '0;
            bit_cnt  <= '0;
            car_cnt  <= '0;
            tx_shift <= '0;
        end else begin
            sym_cnt <= sym_end ? '0 : sym_cnt + 1'b1;
            if (sym_end) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end
            // Carrier restarts each symbol so every symbol sees the same phase.
            car_cnt <= (sym_end || car_cnt == CAR_LAST) ? '0 : car_cnt + 1'b1;
            if (frame_start) begin
                tx_shift <= data_in;
            end else if (sym_end && bit_cnt != BIT_LAST) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    // p0 -> p1: modulator register and matching one-cycle-delayed symbol window
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ask_mod_p1    <= 1'b0;
            window_end_p1 <= 1'b0;
        end else begin
            ask_mod_p1    <= tx_bit & carrier;
            window_end_p1 <= sym_end;
        end
    end

    ask_demod #(
        .SYM_CYCLES(SYM_CYCLES),
        .THRESH    (THRESH)
    ) u_demod (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .ask_mod   (ask_mod_p1),
        .window_end(window_end_p1),
        .data_out  (data_out),
        .data_valid(data_valid)
    );

`ifdef DOUBLE_ASK_MOD_OUT_EN
    assign ask_mod_o = ask_mod_p1;
`endif

endmodule

// File: tb/tb_double_ask_top.sv
// Scoreboard bench for double_ask_top: expected strobes queued by stimulus, popped by a monitor.
module tb_double_ask_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic        data_out;
    logic        data_valid;
    logic        mod_obs;

    typedef struct {
        logic val;
        int   cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          p_start = 0;
    int          checks = 0;
    int          failures = 0;
    logic        mod_en = 1'b0;
    logic [15:0] mod_word = 16'h0000;

`ifdef DOUBLE_ASK_MOD_OUT_EN
    logic ask_mod_o;
    double_ask_top dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .ask_mod_o (ask_mod_o)
    );
    assign mod_obs = ask_mod_o;
`else
    double_ask_top dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid)
    );
    assign mod_obs = dut.ask_mod_p1;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: strobe scoreboard plus optional cycle-by-cycle modulator model.
    always @(negedge clk) begin
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                check("strobe_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_bit", {31'd0, data_out}, {31'd0, e.val});
                check("strobe_cycle", cyc, e.cyc);
            end
        end
        if (mod_en) begin
            int   k;
            int   bi;
            logic e_mod;
            k = cyc - 1 - p_start;
            if (k < 0) begin
                e_mod = 1'b0;
            end else begin
                bi    = 15 - ((k / 50) % 16);
                e_mod = mod_word[bi] & ((k % 10) < 5);
            end
            check("ask_mod", {31'd0, mod_obs}, {31'd0, e_mod});
        end
    end

    task automatic apply_reset(input int ncyc, input logic [15:0] word);
        mod_en  = 1'b0;
        data_in = word;
        rst     = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1;
        rst     = 1'b0;
        p_start = cyc;
        @(negedge clk);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_data_out", {31'd0, data_out}, 32'd0);
        check("rst_ask_mod", {31'd0, mod_obs}, 32'd0);
    endtask

    task automatic push_frame(input logic [15:0] word, input int start, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            exp_t e;
            e.val = word[15-k];
            e.cyc = start + 51 + 50 * k;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_pending", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        // All-zero word: sixteen zero strobes, modulator silent.
        apply_reset(5, 16'h0000);
        mod_word = 16'h0000;
        mod_en   = 1'b1;
        push_frame(16'h0000, p_start, 16);
        wait_drain(1000);

        // Mixed pattern held from reset.
        apply_reset(2, 16'hABCD);
        push_frame(16'hABCD, p_start, 16);
        wait_drain(1000);

        // Word changed during bit 5: only the following frame picks it up.
        apply_reset(2, 16'hABCD);
        push_frame(16'hABCD, p_start, 16);
        push_frame(16'h1234, p_start + 800, 16);
        repeat (270) @(posedge clk);
        #1;
        data_in = 16'h1234;
        wait_drain(1800);

        // All ones across a frame boundary, carrier toggling throughout.
        apply_reset(2, 16'hFFFF);
        mod_word = 16'hFFFF;
        mod_en   = 1'b1;
        push_frame(16'hFFFF, p_start, 16);
        push_frame(16'hFFFF, p_start + 800, 16);
        wait_drain(1800);

        // Single MSB: carrier bursts only during the first symbol.
        apply_reset(2, 16'h8000);
        mod_word = 16'h8000;
        mod_en   = 1'b1;
        push_frame(16'h8000, p_start, 16);
        wait_drain(1000);

        // One-cycle reset in the middle of bit 7 aborts the frame.
        apply_reset(2, 16'hABCD);
        push_frame(16'hABCD, p_start, 7);
        repeat (375) @(posedge clk);
        #1;
        data_in = 16'hC3A5;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        p_start = cyc;
        @(negedge clk);
        check("abort_data_valid", {31'd0, data_valid}, 32'd0);
        check("abort_data_out", {31'd0, data_out}, 32'd0);
        check("abort_pending", exp_q.size(), 32'd0);
        push_frame(16'hC3A5, p_start, 16);
        wait_drain(1000);

        mod_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/double_ask_top.md
Name: double_ask_top

Overview:
- 2ASK (on-off keying) loopback block: takes a 16-bit parallel word, serialises it MSB first, and modulates a digital square-wave carrier.
- The modulated stream is demodulated internally by integrate-and-dump. Recovered bits appear serially with a one-cycle valid strobe.
- Top of the 2ASK link demo; a self-contained modem for bring-up and simulation.

Parameters:
- DATA_W, 16: word width; bits per frame.
- SYM_CYCLES, 50: clocks per symbol (1 us at 50 MHz).
- CARRIER_DIV, 10: carrier period in clocks; must be even and divide SYM_CYCLES.
- THRESH, SYM_CYCLES/4 (12): minimum count of high samples per symbol that decodes as 1.

Ports:
- sys_clk, input, 1: system clock, 50 MHz.
- sys_rst, input, 1: synchronous, active-high reset.
- data_in, input, DATA_W: parallel word; sampled only at frame start.
- data_out, output, 1: last recovered bit; held between strobes.
- data_valid, output, 1: one-cycle strobe marking a new data_out value.

Behaviour:
- Reset (sys_rst high at a sys_clk edge): all counters, shift register, accumulator, data_out and data_valid go to 0. Reset mid-frame aborts the frame; no strobe is produced for the partial symbol.
- Timing:
  - sym_cnt runs 0..SYM_CYCLES-1 and wraps.
  - bit_cnt advances on each sym_cnt wrap, 0..DATA_W-1, and wraps.
  - Carrier counter car_cnt runs 0..CARRIER_DIV-1 and is cleared whenever sym_cnt==0, giving identical phase every symbol.
  - carrier = (car_cnt < CARRIER_DIV/2).
- Frame load:
  - When sym_cnt==0 and bit_cnt==0, data_in is captured into tx_shift. This includes the first cycle after reset release.
  - data_in changes at other times have no effect until the next frame load.
- TX bit:
  - tx_bit = tx_shift[DATA_W-1].
  - tx_shift shifts left (zero fill) at each symbol end, except at the frame's last symbol end, where the reload occurs instead.
- Modulation: ask_mod register <= tx_bit & carrier (1-cycle latency).
- Demodulation (ask_demod):
  - The window is the TX symbol delayed by 1 cycle, to align with ask_mod.
  - The accumulator sums ask_mod over SYM_CYCLES samples.
  - At the window's final sample: data_out <= (acc + sample >= THRESH), data_valid <= 1 for exactly one cycle, and the accumulator restarts from 0.
  - Accumulator width is clog2(SYM_CYCLES+1); it never wraps.
- Latency and ideal counts:
  - data_valid for a symbol starting at cycle T asserts at cycle T+SYM_CYCLES+1.
  - Strobes are exactly SYM_CYCLES apart; DATA_W strobes per frame, MSB first.
  - Ideal counts: bit 1 -> SYM_CYCLES/2 (25); bit 0 -> 0.
- Continuous operation: no idle gap between frames. Back-to-back frames repeat data_in indefinitely.

Optional Feature:
- Macro DOUBLE_ASK_MOD_OUT_EN.
- Defined: an extra output port ask_mod_o (1 bit) exposes the registered modulated signal for scope/DAC use. It resets to 0.
- Undefined: the port is absent. Internal behaviour and all other timing are identical.

Decomposition:
- Shared package double_ask_pkg holds:
  - default constants: DATA_W, SYM_CYCLES, CARRIER_DIV, THRESH;
  - a localparam function for accumulator width (clog2).
- Top contains the timing generator, frame loader/serialiser and modulator.
- One sub-module, ask_demod (inputs: clk, rst, ask_mod, window_end; outputs: data_out, data_valid), holds the integrate-and-dump and threshold logic.

Test Plan:
- Reset held 5 cycles with data_in=16'h0000, then released: first strobe 51 cycles after release. Sixteen strobes, 50 cycles apart, all data_out=0. ask_mod stays 0.
- data_in=16'hABCD stable from reset: strobes yield 1,0,1,0,1,0,1,1,1,1,0,0,1,1,0,1. The accumulator value at each decision is 25 for 1 and 0 for 0.
- data_in set to 16'hABCD, changed to 16'h1234 mid-frame at bit 5: the current frame still yields ABCD. The next frame yields 0,0,0,1,0,0,1,0,0,0,1,1,0,1,0,0.
- data_in=16'hFFFF for two frames: 32 consecutive strobes with data_out=1 and no gap at the frame boundary. ask_mod toggles every 5 cycles continuously.
- sys_rst asserted for 1 cycle mid-symbol of bit 7: data_out=0 and data_valid=0 the next cycle. No strobe for the aborted symbol. A fresh frame reloads data_in, and its first strobe comes 51 cycles after reset release.
- Build with DOUBLE_ASK_MOD_OUT_EN and data_in=16'h8000: ask_mod_o shows 5-high/5-low for 50 cycles during bit 15, then stays low for the remaining 750 cycles of the frame.
